ahb_slave_mem: RTL and testbench

//   AHB-Lite responder: word-addressed SRAM with configurable wait states.

---
 rtl/ahb_slave_mem.sv | 118 +++++++++++
 tb/tb_ahb_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed SRAM responder with a fixed number of wait states per OKAY
// data phase and a two-cycle ERROR response for illegal size, alignment or address.
module ahb_slave_mem #(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic [7:0]  err_cnt
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    wait_cnt_reg;
    logic [AW-1:0] idx_reg;
    logic          write_reg;
    logic [7:0]    err_cnt_reg;
    logic [31:0]   mem [DEPTH];

    logic [31:0] offset;
    logic        in_range;
    logic        legal;
    logic        can_accept;
    logic        accept;
    logic        unused_bits;

    assign offset     = haddr - BASE_ADDR;
    assign in_range   = (haddr >= BASE_ADDR) && ({2'b00, offset[31:2]} < DEPTH);
    assign legal      = (hsize == 3'b010) && (haddr[1:0] == 2'b00) && in_range;
    // A new address phase can only be taken while the bus sees hreadyout high.
    assign can_accept = (state_reg == S_IDLE) || (state_reg == S_DATA) || (state_reg == S_ERR2);
    assign accept     = can_accept && hsel && htrans[1] && hready;
    assign err_cnt    = err_cnt_reg;
    assign unused_bits = ^{htrans[0], offset[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            idx_reg      <= '0;
            write_reg    <= 1'b0;
            err_cnt_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                idx_reg      <= offset[AW+1:2];
                write_reg    <= hwrite;
                wait_cnt_reg <= WAIT_LOAD;
            end else if (state_reg == S_WAIT && wait_cnt_reg != 4'd0) begin
                wait_cnt_reg <= wait_cnt_reg - 4'd1;
            end
            if (state_reg == S_ERR2 && err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    // Storage is deliberately not reset; a write only commits in the final OKAY cycle.
    always_ff @(posedge clk) begin
        if (state_reg == S_DATA && write_reg) begin
            mem[idx_reg] <= hwdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        hrdata     = 32'h0;
        unique case (state_reg)
            S_IDLE, S_DATA, S_ERR2: begin
                if (state_reg == S_DATA && !write_reg) begin
                    hrdata = mem[idx_reg];
                end
                if (state_reg == S_ERR2) begin
                    hresp = 1'b1;
                end
                if (accept) begin
                    if (!legal) begin
                        state_next = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_DATA;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (wait_cnt_reg == 4'd0) begin
                    state_next = S_DATA;
                end
            end
            S_ERR1: begin
                hreadyout  = 1'b0;
                hresp      = 1'b1;
                state_next = S_ERR2;
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (one wait state at base 0, zero wait states at a
// non-zero base) driven by a pipelined AHB master and checked against a transfer-level model.
module tb_ahb_slave_mem;
    localparam int          DEPTH1 = 256;
    localparam logic [31:0] BASE1  = 32'h0000_0000;
    localparam int          WS1    = 1;
    localparam int          DEPTH0 = 64;
    localparam logic [31:0] BASE0  = 32'h0000_0400;
    localparam int          WS0    = 0;

    typedef struct {
        int          d;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } xfer_t;

    typedef struct {
        int          d;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [7:0]  exp_ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hsel0 = 1'b0, hsel1 = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b010;
    logic        hwrite = 1'b0;
    logic [31:0] haddr = 32'h0, hwdata = 32'h0;
    logic        hreadyout0, hresp0, hreadyout1, hresp1;
    logic [31:0] hrdata0, hrdata1;
    logic [7:0]  err_cnt0, err_cnt1;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cur = 1;
    xfer_t       xq[$];
    logic [31:0] ref_mem [2][256];
    int          ref_err [2];
    vec_t        tbl [11];

    logic        m_rdy, m_resp;
    logic [31:0] m_rdata;
    logic [7:0]  m_ec;
    assign m_rdy   = (cur == 1) ? hreadyout1 : hreadyout0;
    assign m_resp  = (cur == 1) ? hresp1     : hresp0;
    assign m_rdata = (cur == 1) ? hrdata1    : hrdata0;
    assign m_ec    = (cur == 1) ? err_cnt1   : err_cnt0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.DEPTH(DEPTH1), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rstn(rstn), .hsel(hsel1), .htrans(htrans), .hsize(hsize),
        .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hready(hreadyout1),
        .hreadyout(hreadyout1), .hresp(hresp1), .hrdata(hrdata1), .err_cnt(err_cnt1)
    );

    ahb_slave_mem #(.DEPTH(DEPTH0), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .rstn(rstn), .hsel(hsel0), .htrans(htrans), .hsize(hsize),
        .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hready(hreadyout0),
        .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0), .err_cnt(err_cnt0)
    );

    function automatic int depth_of(input int d);
        return (d == 1) ? DEPTH1 : DEPTH0;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? BASE1 : BASE0;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 1) ? WS1 : WS0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transfer-level model: legality from the address map, in-order commit of writes.
    task automatic model_xfer(input int d, input bit wr, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output xfer_t x);
        logic [31:0] base;
        bit          ok;
        int          idx;
        base = base_of(d);
        ok   = (size == 3'b010) && (addr[1:0] == 2'b00) && (addr >= base)
               && (((addr - base) / 4) < depth_of(d));
        idx  = ok ? int'((addr - base) / 4) : 0;
        x.d = d; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        x.exp_err = !ok;
        x.exp_rd  = 32'h0;
        if (ok && wr) ref_mem[d][idx] = wdata;
        if (ok && !wr) x.exp_rd = ref_mem[d][idx];
        if (!ok && ref_err[d] < 255) ref_err[d]++;
    endtask

    task automatic add_xfer(input int d, input bit wr, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        model_xfer(d, wr, size, addr, wdata, x);
        xq.push_back(x);
    endtask

    task automatic drive_addr(input int i);
        if (i < xq.size()) begin
            hsel0  = (xq[i].d == 0);
            hsel1  = (xq[i].d == 1);
            htrans = (i % 2 == 1) ? 2'b11 : 2'b10;
            hsize  = xq[i].size;
            hwrite = xq[i].wr;
            haddr  = xq[i].addr;
        end else begin
            hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
            hsize = 3'b010; hwrite = 1'b0; haddr = 32'h0;
        end
    endtask

    // Pipelined master: next address is presented during the current data phase.
    task automatic run_q();
        int          ai, di, cyc, guard, lat;
        bit          rdy;
        xfer_t       x;
        logic [31:0] exp_hd;
        if (xq.size() == 0) return;
        cur = xq[0].d;
        ai = 0; di = -1; cyc = 0; guard = 0;
        @(posedge clk); #1;
        drive_addr(0);
        forever begin
            @(negedge clk);
            rdy = m_rdy;
            if (di < 0) begin
                check("idle outputs", 64'({m_rdy, m_resp, m_rdata}), 64'({1'b1, 1'b0, 32'h0}));
            end else begin
                x = xq[di];
                cyc++;
                lat = x.exp_err ? 2 : ws_of(x.d) + 1;
                exp_hd = (cyc >= lat && !x.wr && !x.exp_err) ? x.exp_rd : 32'h0;
                check($sformatf("dphase d%0d #%0d cyc%0d", x.d, di, cyc),
                      64'({m_rdy, m_resp, m_rdata}), 64'({cyc >= lat, x.exp_err, exp_hd}));
                if (rdy)
                    $display("xfer d%0d %s addr=%h wdata=%h hresp=%0d hrdata=%h cycles=%0d",
                             x.d, x.wr ? "WR" : "RD", x.addr, x.wdata, m_resp, m_rdata, cyc);
            end
            @(posedge clk); #1;
            if (rdy) begin
                if (ai < xq.size()) begin
                    di = ai;
                    ai++;
                end else begin
                    di = -1;
                end
                cyc = 0;
                hwdata = (di >= 0) ? xq[di].wdata : 32'h0;
                drive_addr(ai);
            end
            if (di < 0 && ai >= xq.size()) break;
            guard++;
            if (guard > 4 * xq.size() + 40) begin
                n_vec++; n_bad++;
                $display("FAIL timeout: %0d cycles without completing %0d transfers", guard, xq.size());
                break;
            end
        end
        drive_addr(xq.size());
        xq.delete();
        @(negedge clk);
        check($sformatf("err_cnt d%0d", cur), 64'(m_ec), 64'(ref_err[cur]));
    endtask

    task automatic random_xfer(input int d);
        int          kind;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] base;
        base = base_of(d);
        kind = $urandom_range(0, 9);
        sz   = 3'b010;
        case (kind)
            0: a = base + 4 * $urandom_range(0, depth_of(d) - 1) + $urandom_range(1, 3);
            1: begin
                a  = base + 4 * $urandom_range(0, depth_of(d) - 1);
                sz = 3'($urandom_range(0, 7));
                if (sz == 3'b010) sz = 3'b011;
            end
            2: a = base + 4 * depth_of(d) + 4 * $urandom_range(0, 15);
            3: a = (base >= 64) ? base - 4 * $urandom_range(1, 16) : base + 4 * depth_of(d);
            4, 5, 6: a = base + 4 * $urandom_range(0, 15);
            default: a = base + 4 * $urandom_range(0, depth_of(d) - 1);
        endcase
        add_xfer(d, $urandom_range(0, 1) == 1, sz, a, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ref_err[0] = 0;
        ref_err[1] = 0;
        //        d  wr  size    addr           wdata          err  rdata          err_cnt
        tbl = '{
            '{1, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         8'd0},
            '{1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 8'd0},
            '{1, 1'b0, 3'd2, 32'h0000_0400, 32'h0,         1'b1, 32'h0,         8'd1},
            '{1, 1'b1, 3'd0, 32'h0000_0014, 32'h1111_1111, 1'b1, 32'h0,         8'd2},
            '{1, 1'b1, 3'd2, 32'h0000_0002, 32'h2222_2222, 1'b1, 32'h0,         8'd3},
            '{1, 1'b0, 3'd2, 32'h0000_0014, 32'h0,         1'b0, 32'hC0DE_0105, 8'd3},
            '{1, 1'b0, 3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'hC0DE_0100, 8'd3},
            '{0, 1'b0, 3'd2, 32'h0000_03FC, 32'h0,         1'b1, 32'h0,         8'd1},
            '{0, 1'b0, 3'd2, 32'h0000_04FC, 32'h0,         1'b0, 32'hC0DE_003F, 8'd1},
            '{0, 1'b0, 3'd2, 32'h0000_0500, 32'h0,         1'b1, 32'h0,         8'd2},
            '{1, 1'b0, 3'd2, 32'h0000_03FC, 32'h0,         1'b0, 32'hC0DE_01FF, 8'd3}
        };

        // Reset values while rstn is held low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset d1", 64'({hreadyout1, hresp1, hrdata1, err_cnt1}), 64'({1'b1, 1'b0, 32'h0, 8'h0}));
        check("reset d0", 64'({hreadyout0, hresp0, hrdata0, err_cnt0}), 64'({1'b1, 1'b0, 32'h0, 8'h0}));
        rstn = 1'b1;

        // Known contents everywhere: word i of instance d holds C0DE_ddii.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < depth_of(d); i++)
                add_xfer(d, 1'b1, 3'b010, base_of(d) + 4 * i, {16'hC0DE, 8'(d), 8'(i)});
            run_q();
        end

        foreach (tbl[i]) begin
            xfer_t x;
            model_xfer(tbl[i].d, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, x);
            x.exp_err = tbl[i].exp_err;
            x.exp_rd  = tbl[i].exp_rd;
            xq.push_back(x);
            run_q();
            check($sformatf("tbl%0d err_cnt", i), 64'(m_ec), 64'(tbl[i].exp_ec));
        end

        // Zero wait states: back-to-back writes then reads, one cycle per data phase.
        for (int i = 0; i < 3; i++)
            add_xfer(0, 1'b1, 3'b010, BASE0 + 4 * i, 32'h5A5A_0000 + 32'(i));
        for (int i = 0; i < 3; i++)
            add_xfer(0, 1'b0, 3'b010, BASE0 + 4 * i, 32'h0);
        run_q();

        // BUSY then IDLE with hsel high: no transfer, no error counted.
        @(posedge clk); #1;
        cur = 1; hsel1 = 1'b1; htrans = 2'b01; hsize = 3'b010; hwrite = 1'b1;
        haddr = 32'h10; hwdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        check("busy outputs", 64'({m_rdy, m_resp, m_rdata}), 64'({1'b1, 1'b0, 32'h0}));
        @(posedge clk); #1;
        hsel1 = 1'b0; hwrite = 1'b0;
        @(negedge clk);
        check("idle outputs hsel", 64'({m_rdy, m_resp, m_rdata}), 64'({1'b1, 1'b0, 32'h0}));
        check("busy err_cnt", 64'(m_ec), 64'(ref_err[1]));
        add_xfer(1, 1'b0, 3'b010, 32'h10, 32'h0);
        run_q();

        // Randomised traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 3; b++) begin
                repeat (40) random_xfer(d);
                run_q();
            end
        end

        // Reset during the wait state of a write: the write must be dropped.
        add_xfer(1, 1'b1, 3'b010, 32'h20, 32'h1234_5678);
        run_q();
        @(posedge clk); #1;
        cur = 1; hsel1 = 1'b1; htrans = 2'b10; hsize = 3'b010; hwrite = 1'b1; haddr = 32'h20;
        @(posedge clk); #1;
        hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFF_0000;
        @(negedge clk);
        check("write in wait", 64'({m_rdy, m_resp}), 64'({1'b0, 1'b0}));
        #2 rstn = 1'b0;
        #1;
        check("reset at once", 64'({m_rdy, m_resp, m_rdata}), 64'({1'b1, 1'b0, 32'h0}));
        check("reset err_cnt", 64'({err_cnt1, err_cnt0}), 64'(16'h0));
        ref_err[0] = 0;
        ref_err[1] = 0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        add_xfer(1, 1'b0, 3'b010, 32'h20, 32'h0);
        add_xfer(1, 1'b1, 3'b010, 32'h24, 32'h0BAD_CAFE);
        add_xfer(1, 1'b0, 3'b010, 32'h24, 32'h0);
        run_q();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
